// File: rtl/alu_exec.sv
// Multi-cycle execute unit. Logic and add/sub ops complete on the accept edge.
// Shifts and multiply iterate in EXEC under a down-counter. Results are handed back over valid/ready.
module alu_exec #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;

  logic [WIDTH:0]       add_s, sub_s, mac_s;
  logic [2*WIDTH-1:0]   step_s;
  logic                 step_cy_s;
  logic                 load_s;
  logic [WIDTH-1:0]     res_s;
  logic                 cy_s;

  // Next-state, datapath step and result capture.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mcand_d   = mcand_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    load_s    = 1'b0;
    res_s     = {WIDTH{1'b0}};
    cy_s      = 1'b0;
    add_s     = {1'b0, a} + {1'b0, b};
    sub_s     = {1'b0, a} - {1'b0, b};
    mac_s     = {1'b0, work_q[2*WIDTH-1:WIDTH]} + ({1'b0, mcand_q} & {(WIDTH+1){work_q[0]}});

    // Multiply keeps the partial product in the upper half and the multiplier in the lower half.
    case (op_q)
      OP_SHL: begin
        step_s    = {{WIDTH{1'b0}}, work_q[WIDTH-2:0], 1'b0};
        step_cy_s = work_q[WIDTH-1];
      end
      OP_SHR: begin
        step_s    = {{WIDTH{1'b0}}, 1'b0, work_q[WIDTH-1:1]};
        step_cy_s = work_q[0];
      end
      OP_MUL: begin
        step_s    = {mac_s, work_q[WIDTH-1:1]};
        step_cy_s = |mac_s[WIDTH:1];
      end
      default: begin
        step_s    = work_q;
        step_cy_s = 1'b0;
      end
    endcase

    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          op_d = op;
          case (op)
            OP_ADD: begin load_s = 1'b1; res_s = add_s[WIDTH-1:0]; cy_s = add_s[WIDTH]; state_d = S_DONE; end
            OP_SUB: begin load_s = 1'b1; res_s = sub_s[WIDTH-1:0]; cy_s = sub_s[WIDTH]; state_d = S_DONE; end
            OP_AND: begin load_s = 1'b1; res_s = a & b; state_d = S_DONE; end
            OP_OR:  begin load_s = 1'b1; res_s = a | b; state_d = S_DONE; end
            OP_XOR: begin load_s = 1'b1; res_s = a ^ b; state_d = S_DONE; end
            OP_SHL, OP_SHR: begin
              if (b[2:0] == 3'd0) begin
                load_s  = 1'b1;
                res_s   = a;
                state_d = S_DONE;
              end else begin
                work_d  = {{WIDTH{1'b0}}, a};
                cnt_d   = CW'(b[2:0]);
                state_d = S_EXEC;
              end
            end
            OP_MUL: begin
              mcand_d = a;
              work_d  = {{WIDTH{1'b0}}, b};
              cnt_d   = CW'(WIDTH);
              state_d = S_EXEC;
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        work_d = step_s;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          load_s  = 1'b1;
          res_s   = step_s[WIDTH-1:0];
          cy_s    = step_cy_s;
          state_d = S_DONE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flags move only together with a freshly produced result.
    result_d = load_s ? res_s : result_q;
    zero_d   = load_s ? (res_s == {WIDTH{1'b0}}) : zero_q;
    carry_d  = load_s ? cy_s : carry_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      mcand_q  <= {WIDTH{1'b0}};
      work_q   <= {(2*WIDTH){1'b0}};
      cnt_q    <= {CW{1'b0}};
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  assign op_ready   = (state_q == S_IDLE);
  assign res_valid  = (state_q == S_DONE);
  assign result     = result_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;

endmodule
